// File: rtl/if_prefetch_pkg.sv
// if_prefetch_pkg: bus widths, control-flow opcodes and the predecode predicate for the fetch stage
package if_prefetch_pkg;
    localparam int ADDRBUS = 16;
    localparam int DATABUS = 16;
    localparam logic [4:0] OP_BEQ = 5'h1C;
    localparam logic [4:0] OP_BLE = 5'h1D;
    localparam logic [4:0] OP_JAL = 5'h1E;
    localparam logic [4:0] OP_JR  = 5'h1F;
    function automatic logic is_ctrl(input logic [4:0] op);
        return op == OP_BEQ || op == OP_BLE || op == OP_JAL || op == OP_JR;
    endfunction
endpackage

// File: rtl/if_fifo.sv
// if_fifo: synchronous FIFO with flush; head shows the oldest entry, count covers every stored word
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_cnt;
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= i_push ? r_wr + AW'(1) : r_wr;
            r_rd  <= i_pop ? r_rd + AW'(1) : r_rd;
            r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end
    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: credit-limited instruction prefetch with redirect flush and control-flow fetch blocking
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDRBUS,
    parameter int                DATA_W   = DATABUS,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic              br_resolve,
    input  logic              fetch_hold,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              hold_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_W-1:0]        r_fetch_pc, r_resp_pc;
    logic [CW-1:0]            r_out, r_drop, w_count, w_owed;
    logic                     r_br_block;
    logic [ADDR_W+DATA_W-1:0] w_head;
    logic                     w_grant, w_drop_now, w_push, w_valid;
    // Credits cover words in flight plus words buffered, so the FIFO can never overflow.
    assign imem_req   = rst_n & ~jump_flag & ~fetch_hold & ~r_br_block &
                        ((CW+1)'(r_out) + (CW+1)'(w_count) < (CW+1)'(DEPTH));
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req & imem_gnt;
    assign w_drop_now = imem_rvalid & (r_drop != '0);
    assign w_push     = imem_rvalid & ~w_drop_now & ~jump_flag;
    assign w_owed     = r_out + CW'(w_grant) - CW'(imem_rvalid);
    assign w_valid    = w_count != '0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop     <= '0;
            r_br_block <= 1'b0;
        end else if (jump_flag) begin
            r_fetch_pc <= jump_pc;
            r_resp_pc  <= jump_pc;
            r_out      <= w_owed;
            r_drop     <= w_owed + r_drop - CW'(w_drop_now);
            r_br_block <= 1'b0;
        end else begin
            r_fetch_pc <= w_grant ? r_fetch_pc + ADDR_W'(1) : r_fetch_pc;
            r_resp_pc  <= w_push ? r_resp_pc + ADDR_W'(1) : r_resp_pc;
            r_out      <= w_owed;
            r_drop     <= r_drop - CW'(w_drop_now);
            r_br_block <= (w_push && is_ctrl(imem_rdata[4:0])) || (r_br_block && !br_resolve);
        end
    end
    if_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W + DATA_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (jump_flag),
        .i_push  (w_push),
        .i_pop   (w_valid & inst_ready),
        .i_data  ({r_resp_pc, imem_rdata}),
        .o_head  (w_head),
        .o_count (w_count)
    );
    assign inst_valid = w_valid;
    assign inst_pc    = w_valid ? w_head[ADDR_W+DATA_W-1:DATA_W] : RESET_PC;
    assign inst_data  = w_valid ? w_head[DATA_W-1:0] : '0;
    assign hold_pc    = r_br_block;
endmodule
